// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry,
// on/off flag values and the depth helper.
package regfile_sb_pkg;

  localparam int BIT_DATA_DEF = 8;
  localparam int SZB_DEF      = 4;
  localparam int SZA_DEF      = 1 << SZB_DEF;

  localparam bit OFF = 1'b0;
  localparam bit ON  = 1'b1;

  // Register count for a given address width.
  function automatic int sza_of(input int szb);
    return 1 << szb;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy scoreboard: one pending bit per register, set at issue and cleared at
// writeback or move, plus a sticky flag for moves that read a pending register.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int SZB     = SZB_DEF,
  parameter bit ZERO_R0 = OFF,
  localparam int SZA    = sza_of(SZB)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           issue_en,
  input  logic [SZB-1:0] issue_addr,
  input  logic           rd_we,
  input  logic [SZB-1:0] addr_rd,
  input  logic           en_mv,
  input  logic [SZB-1:0] addr_mv_src,
  input  logic [SZB-1:0] addr_mv_dst,
  output logic [SZA-1:0] busy,
  output logic           mv_hazard
);

  logic [SZA-1:0] busy_r;
  logic [SZA-1:0] busy_nxt_s;
  logic           mv_hazard_r;
  logic           hazard_hit_s;

  // Next busy vector: a new issue supersedes a completing producer.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 0; r < SZA; r++) begin
      if (ZERO_R0 == ON && r == 0) begin
        busy_nxt_s[r] = 1'b0;
      end else if (issue_en && issue_addr == SZB'(r)) begin
        busy_nxt_s[r] = 1'b1;
      end else if ((rd_we && addr_rd == SZB'(r)) || (en_mv && addr_mv_dst == SZB'(r))) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Move source still pending means the move copied a stale value.
  always_comb begin
    if (en_mv) begin
      hazard_hit_s = busy_r[addr_mv_src];
    end else begin
      hazard_hit_s = 1'b0;
    end
  end

  // Scoreboard state and sticky hazard flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_r      <= {SZA{1'b0}};
      mv_hazard_r <= 1'b0;
    end else begin
      busy_r      <= busy_nxt_s;
      mv_hazard_r <= mv_hazard_r | hazard_hit_s;
    end
  end

  assign busy      = busy_r;
  assign mv_hazard = mv_hazard_r;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with writeback and move write paths, optional
// writeback-to-read bypass, optional hardwired-zero r0 and a busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int BIT_DATA = BIT_DATA_DEF,
  parameter int SZB      = SZB_DEF,
  parameter int N_RD     = 2,
  parameter bit BYPASS   = ON,
  parameter bit ZERO_R0  = OFF,
  localparam int SZA     = sza_of(SZB)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rd_we,
  input  logic [SZB-1:0]           addr_rd,
  input  logic [BIT_DATA-1:0]      rd,
  input  logic                     en_mv,
  input  logic [SZB-1:0]           addr_mv_src,
  input  logic [SZB-1:0]           addr_mv_dst,
  input  logic [N_RD*SZB-1:0]      addr_rs,
  output logic [N_RD*BIT_DATA-1:0] rs,
  output logic [N_RD-1:0]          rs_busy,
  input  logic                     issue_en,
  input  logic [SZB-1:0]           issue_addr,
  output logic [SZA-1:0]           busy,
  output logic                     mv_hazard
);

  logic [BIT_DATA-1:0] regf_r [SZA];
  logic                wb_we_s;
  logic                mv_we_s;
  logic [BIT_DATA-1:0] mv_data_s;
  logic [SZA-1:0]      busy_s;

  // Write-path qualification: writeback beats a move to the same destination.
  always_comb begin
    wb_we_s = 1'b0;
    mv_we_s = 1'b0;
    if (ZERO_R0 == ON && addr_rd == {SZB{1'b0}}) begin
      wb_we_s = 1'b0;
    end else begin
      wb_we_s = rd_we;
    end
    if (ZERO_R0 == ON && addr_mv_dst == {SZB{1'b0}}) begin
      mv_we_s = 1'b0;
    end else if (rd_we && addr_rd == addr_mv_dst) begin
      mv_we_s = 1'b0;
    end else begin
      mv_we_s = en_mv;
    end
  end

  // Move data is the pre-edge register value, never forwarded writeback data.
  always_comb begin
    if (ZERO_R0 == ON && addr_mv_src == {SZB{1'b0}}) begin
      mv_data_s = {BIT_DATA{1'b0}};
    end else begin
      mv_data_s = regf_r[addr_mv_src];
    end
  end

  // Register storage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < SZA; i++) begin
        regf_r[i] <= {BIT_DATA{1'b0}};
      end
    end else begin
      if (mv_we_s) begin
        regf_r[addr_mv_dst] <= mv_data_s;
      end
      if (wb_we_s) begin
        regf_r[addr_rd] <= rd;
      end
    end
  end

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [SZB-1:0]      addr_s;
    logic [BIT_DATA-1:0] data_s;

    assign addr_s = addr_rs[g*SZB +: SZB];

    // Read mux: hardwired zero first, then same-cycle writeback, then storage.
    always_comb begin
      if (ZERO_R0 == ON && addr_s == {SZB{1'b0}}) begin
        data_s = {BIT_DATA{1'b0}};
      end else if (BYPASS == ON && rd_we && addr_rd == addr_s) begin
        data_s = rd;
      end else begin
        data_s = regf_r[addr_s];
      end
    end

    assign rs[g*BIT_DATA +: BIT_DATA] = data_s;
    assign rs_busy[g]                 = busy_s[addr_s];
  end

  regfile_sb_scoreboard #(
    .SZB     (SZB),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .rd_we       (rd_we),
    .addr_rd     (addr_rd),
    .en_mv       (en_mv),
    .addr_mv_src (addr_mv_src),
    .addr_mv_dst (addr_mv_dst),
    .busy        (busy_s),
    .mv_hazard   (mv_hazard)
  );

  assign busy = busy_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two configurations (bypass / zero-r0) share
// one stimulus stream and are checked against an array-based reference model.
module tb_regfile_sb;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Applied inputs (shared by both instances).
  logic       d_reset = 1'b0, d_rd_we = 1'b0, d_en_mv = 1'b0, d_issue_en = 1'b0;
  logic [3:0] d_addr_rd = 4'd0, d_src = 4'd0, d_dst = 4'd0, d_issue_addr = 4'd0;
  logic [7:0] d_rd = 8'd0;
  logic [3:0] d_rs0 = 4'd0, d_rs1 = 4'd0;
  // Staged inputs for the next cycle.
  logic       n_reset, n_rd_we, n_en_mv, n_issue_en;
  logic [3:0] n_addr_rd, n_src, n_dst, n_issue_addr, n_rs0, n_rs1;
  logic [7:0] n_rd;

  logic [15:0] rs_a, rs_b, busy_a, busy_b;
  logic [1:0]  rsb_a, rsb_b;
  logic        haz_a, haz_b;

  regfile_sb #(.BIT_DATA(8), .SZB(4), .N_RD(2), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_a (
    .clock(clock), .reset(d_reset), .rd_we(d_rd_we), .addr_rd(d_addr_rd), .rd(d_rd),
    .en_mv(d_en_mv), .addr_mv_src(d_src), .addr_mv_dst(d_dst), .addr_rs({d_rs1, d_rs0}),
    .rs(rs_a), .rs_busy(rsb_a), .issue_en(d_issue_en), .issue_addr(d_issue_addr),
    .busy(busy_a), .mv_hazard(haz_a));

  regfile_sb #(.BIT_DATA(8), .SZB(4), .N_RD(2), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_b (
    .clock(clock), .reset(d_reset), .rd_we(d_rd_we), .addr_rd(d_addr_rd), .rd(d_rd),
    .en_mv(d_en_mv), .addr_mv_src(d_src), .addr_mv_dst(d_dst), .addr_rs({d_rs1, d_rs0}),
    .rs(rs_b), .rs_busy(rsb_b), .issue_en(d_issue_en), .issue_addr(d_issue_addr),
    .busy(busy_b), .mv_hazard(haz_b));

  // Reference model: plain arrays, one set per instance.
  logic [7:0] m_reg  [2][16];
  bit         m_busy [2][16];
  bit         m_haz  [2];
  bit         cfg_byp [2] = '{1'b1, 1'b0};
  bit         cfg_zero[2] = '{1'b0, 1'b1};

  typedef struct {
    int          inst;
    logic [15:0] rs;
    logic [1:0]  rsb;
    logic [15:0] busy;
    logic        haz;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] model_read(int k, logic [3:0] a);
    if (cfg_zero[k] && a == 4'd0) return 8'h00;
    if (cfg_byp[k] && d_rd_we && d_addr_rd == a) return d_rd;
    return m_reg[k][a];
  endfunction

  // Apply one clock edge's worth of architectural effects to the model.
  task automatic model_commit(int k);
    logic [7:0] mv_val;
    bit         src_busy;
    if (!d_reset) begin
      for (int r = 0; r < 16; r++) begin
        m_reg[k][r]  = 8'h00;
        m_busy[k][r] = 1'b0;
      end
      m_haz[k] = 1'b0;
    end else begin
      mv_val   = (cfg_zero[k] && d_src == 4'd0) ? 8'h00 : m_reg[k][d_src];
      src_busy = m_busy[k][d_src];
      if (d_en_mv && !(d_rd_we && d_dst == d_addr_rd)) m_reg[k][d_dst] = mv_val;
      if (d_rd_we) m_reg[k][d_addr_rd] = d_rd;
      if (d_en_mv) m_busy[k][d_dst] = 1'b0;
      if (d_rd_we) m_busy[k][d_addr_rd] = 1'b0;
      if (d_issue_en) m_busy[k][d_issue_addr] = 1'b1;
      if (cfg_zero[k]) begin
        m_reg[k][0]  = 8'h00;
        m_busy[k][0] = 1'b0;
      end
      if (d_en_mv && src_busy) m_haz[k] = 1'b1;
    end
  endtask

  task automatic push_expect(int k);
    exp_t e;
    e.inst = k;
    e.rs   = {model_read(k, d_rs1), model_read(k, d_rs0)};
    e.rsb  = {m_busy[k][d_rs1], m_busy[k][d_rs0]};
    for (int r = 0; r < 16; r++) e.busy[r] = m_busy[k][r];
    e.haz  = m_haz[k];
    exp_q.push_back(e);
  endtask

  task automatic stage_idle();
    n_reset = 1'b1; n_rd_we = 1'b0; n_en_mv = 1'b0; n_issue_en = 1'b0;
    n_addr_rd = 4'd0; n_src = 4'd0; n_dst = 4'd0; n_issue_addr = 4'd0;
    n_rd = 8'h00; n_rs0 = 4'd0; n_rs1 = 4'd0;
  endtask

  // One cycle: model absorbs the edge, staged inputs are driven, expectations queued.
  task automatic tick();
    @(posedge clock);
    #1;
    model_commit(0);
    model_commit(1);
    d_reset = n_reset; d_rd_we = n_rd_we; d_addr_rd = n_addr_rd; d_rd = n_rd;
    d_en_mv = n_en_mv; d_src = n_src; d_dst = n_dst;
    d_issue_en = n_issue_en; d_issue_addr = n_issue_addr;
    d_rs0 = n_rs0; d_rs1 = n_rs1;
    push_expect(0);
    push_expect(1);
    stage_idle();
  endtask

  task automatic check(string name, int k, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t got=%h expected=%h", name, k, $time, act, exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle; pop and compare everything queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.inst == 0) begin
          check("rs", 0, rs_a, e.rs);
          check("rs_busy", 0, {14'd0, rsb_a}, {14'd0, e.rsb});
          check("busy", 0, busy_a, e.busy);
          check("mv_hazard", 0, {15'd0, haz_a}, {15'd0, e.haz});
        end else begin
          check("rs", 1, rs_b, e.rs);
          check("rs_busy", 1, {14'd0, rsb_b}, {14'd0, e.rsb});
          check("busy", 1, busy_b, e.busy);
          check("mv_hazard", 1, {15'd0, haz_b}, {15'd0, e.haz});
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) begin
        m_reg[k][r] = 8'h00; m_busy[k][r] = 1'b0;
      end
      m_haz[k] = 1'b0;
    end
    stage_idle();
    n_reset = 1'b0; tick();
    // Reset after random writes, including a write during reset.
    for (int i = 0; i < 4; i++) begin
      n_rd_we = 1'b1; n_addr_rd = 4'($urandom_range(0, 15)); n_rd = 8'($urandom);
      n_issue_en = 1'b1; n_issue_addr = 4'($urandom_range(0, 15)); tick();
    end
    n_reset = 1'b0; n_rd_we = 1'b1; n_addr_rd = 4'd5; n_rd = 8'h77; tick();
    n_reset = 1'b0; tick();
    n_rs0 = 4'd5; n_rs1 = 4'd3; tick();
    n_rd_we = 1'b1; n_addr_rd = 4'd5; n_rd = 8'h3C; n_rs0 = 4'd5; tick();
    n_rs0 = 4'd5; tick();
    // Bypass vs. pre-edge read.
    n_rd_we = 1'b1; n_addr_rd = 4'd7; n_rd = 8'hA5; n_rs1 = 4'd7; tick();
    n_rs1 = 4'd7; tick();
    // Writeback/move collision, then distinct destinations.
    n_rd_we = 1'b1; n_addr_rd = 4'd2; n_rd = 8'h11; tick();
    n_rd_we = 1'b1; n_addr_rd = 4'd4; n_rd = 8'h99; n_en_mv = 1'b1; n_src = 4'd2; n_dst = 4'd4; tick();
    n_rs0 = 4'd4; tick();
    n_rd_we = 1'b1; n_addr_rd = 4'd4; n_rd = 8'h99; n_en_mv = 1'b1; n_src = 4'd2; n_dst = 4'd6; tick();
    n_rs0 = 4'd4; n_rs1 = 4'd6; tick();
    // Scoreboard set/clear priority.
    n_issue_en = 1'b1; n_issue_addr = 4'd3; n_rs0 = 4'd3; tick();
    n_rs0 = 4'd3; tick();
    n_issue_en = 1'b1; n_issue_addr = 4'd3; n_rd_we = 1'b1; n_addr_rd = 4'd3; n_rd = 8'h42; tick();
    n_rs0 = 4'd3; tick();
    n_rd_we = 1'b1; n_addr_rd = 4'd3; n_rd = 8'h43; tick();
    n_rs0 = 4'd3; tick();
    // Move from a pending register raises the sticky hazard.
    n_rd_we = 1'b1; n_addr_rd = 4'd9; n_rd = 8'h5A; tick();
    n_issue_en = 1'b1; n_issue_addr = 4'd9; tick();
    n_en_mv = 1'b1; n_src = 4'd9; n_dst = 4'd1; tick();
    n_rs0 = 4'd1; tick();
    for (int i = 0; i < 3; i++) tick();
    n_reset = 1'b0; tick();
    tick();
    // Writes, issue and move involving r0.
    n_rd_we = 1'b1; n_addr_rd = 4'd0; n_rd = 8'hFF; n_rs0 = 4'd0; tick();
    n_issue_en = 1'b1; n_issue_addr = 4'd0; n_rs0 = 4'd0; tick();
    n_en_mv = 1'b1; n_src = 4'd0; n_dst = 4'd8; n_rs0 = 4'd0; tick();
    n_rs0 = 4'd0; n_rs1 = 4'd8; tick();
    // Randomised traffic on a mixture of all enables.
    for (int i = 0; i < 400; i++) begin
      n_reset      = ($urandom_range(0, 39) != 0);
      n_rd_we      = 1'($urandom_range(0, 1));
      n_addr_rd    = 4'($urandom_range(0, 15));
      n_rd         = 8'($urandom);
      n_en_mv      = ($urandom_range(0, 2) == 0);
      n_src        = 4'($urandom_range(0, 15));
      n_dst        = ($urandom_range(0, 3) == 0) ? n_addr_rd : 4'($urandom_range(0, 15));
      n_issue_en   = 1'($urandom_range(0, 1));
      n_issue_addr = 4'($urandom_range(0, 15));
      n_rs0        = ($urandom_range(0, 2) == 0) ? n_addr_rd : 4'($urandom_range(0, 15));
      n_rs1        = 4'($urandom_range(0, 15));
      tick();
    end
    tick();
    @(negedge clock);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 8-bit, 16-entry core register file.
- Adds configurable data width, depth and read-port count.
- Adds independent writeback and move write paths, optional writeback-to-read bypass, and optional hardwired-zero r0.
- Adds a per-register busy scoreboard, set at issue and cleared at writeback; the decode/issue stage uses it for hazard stalls.

Parameters:
- BIT_DATA, 8, data width per register.
- SZB, 4, address width; depth SZA = 2**SZB.
- N_RD, 2, number of combinational read ports (1..4).
- BYPASS, 1, 1 = same-cycle writeback data forwarded to matching read ports.
- ZERO_R0, 0, 1 = r0 reads 0, ignores writes, never busy.

Ports:
- clock, in, 1, single clock; all state updates on posedge.
- reset, in, 1, synchronous, active-low (reset asserted when 0, sampled on posedge clock).
- rd_we, in, 1, writeback enable.
- addr_rd, in, SZB, writeback destination.
- rd, in, BIT_DATA, writeback data.
- en_mv, in, 1, register-to-register move enable.
- addr_mv_src, in, SZB, move source.
- addr_mv_dst, in, SZB, move destination.
- addr_rs, in, N_RD*SZB, packed read addresses; port i at bits [i*SZB +: SZB].
- rs, out, N_RD*BIT_DATA, packed read data.
- rs_busy, out, N_RD, busy bit of each read address.
- issue_en, in, 1, marks a register as pending.
- issue_addr, in, SZB, register being issued.
- busy, out, SZA, full scoreboard vector.
- mv_hazard, out, 1, sticky error flag.

Behaviour:
- Reset (reset==0 at posedge):
  - All registers, busy and mv_hazard go to 0.
  - Reset overrides every other input that cycle.
  - rs reads 0 from the next cycle; rs_busy reads 0.
  - Reset mid-operation discards pending writes and issues.
- Reads:
  - Combinational; zero latency: rs[i] = regf[addr_rs[i]].
  - rs_busy[i] = busy[addr_rs[i]].
- Bypass (BYPASS=1):
  - If rd_we && addr_rd==addr_rs[i], then rs[i] = rd in the same cycle.
  - Move data is never bypassed.
  - With BYPASS=0, reads return the pre-edge value.
- Writeback: on posedge with rd_we=1, regf[addr_rd] <= rd.
- Move:
  - On posedge with en_mv=1, regf[addr_mv_dst] <= regf[addr_mv_src], using the pre-edge value (no writeback forwarding).
  - Move completes in one cycle.
- Simultaneous rd_we and en_mv:
  - Different destinations: both writes happen.
  - Same destination: rd_we wins; the move is dropped.
- Scoreboard, per register r, evaluated at each posedge:
  - Set if issue_en && issue_addr==r.
  - Else clear if (rd_we && addr_rd==r) or (en_mv && addr_mv_dst==r).
  - Else hold.
  - Set beats clear on the same register in the same cycle (a new producer supersedes the old one).
- mv_hazard:
  - Set when en_mv=1 and busy[addr_mv_src]=1 at the posedge.
  - The move still executes with the stale value; the issue stage must stall to avoid this.
  - Sticky until reset.
- ZERO_R0=1:
  - Writes/moves to address 0 are ignored.
  - Issue to address 0 is ignored; busy[0] is constant 0.
  - Any read of address 0 returns 0, including under bypass.
  - A move from r0 writes 0.
- Idle cycle (no enables): all state holds.
- Widths: no arithmetic; addresses are always in range since SZA = 2**SZB. No wrap or overflow cases.

Decomposition:
- Shared package/definitions include:
  - Default BIT_DATA and SZB.
  - OFF/ON constants.
  - Helper localparam SZA computed from SZB.
- One natural sub-module: regfile_sb_scoreboard (busy vector, set/clear priority, mv_hazard).
- Storage, write-path priority and read/bypass muxing stay in the top.

Test Plan:
1. Reset: drive reset=0 for 2 cycles after random writes -> all rs=0, busy=0, mv_hazard=0. Release: write r5<=0x3C -> rs[0] with addr 5 reads 0x3C next cycle.
2. Bypass: BYPASS=1, rd_we=1, addr_rd=7, rd=0xA5, addr_rs[1]=7 -> rs[1]=0xA5 in the same cycle. With BYPASS=0 -> rs[1] shows old value 0x00 until after the edge.
3. Collision: r2=0x11; rd_we addr_rd=4 rd=0x99 and en_mv src=2 dst=4 in one cycle -> r4=0x99. Same cycle with dst=6 instead -> r4=0x99 and r6=0x11.
4. Scoreboard: issue r3 -> busy[3]=1 next cycle. Issue r3 plus writeback r3 in the same cycle -> busy[3] stays 1. Writeback r3 alone -> busy[3]=0.
5. Hazard: issue r9, then en_mv src=9 dst=1 -> mv_hazard=1 and r1 gets the old r9 value. mv_hazard persists until reset=0.
6. ZERO_R0=1: write r0<=0xFF, issue r0, move r0->r8 -> r0 reads 0, busy[0]=0, r8=0.
